// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : 8-bit UART transmitter with even parity and a fixed divisor
//             table for a 100 MHz clock. Frame is start, 8 data bits (LSB
//             first), parity, stop. Each bit lasts 16 sample ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Tx_DATA,
   input  logic [2:0] baud_select,
   input  logic       Tx_WR,
   input  logic       Tx_EN,
   output logic       TxD,
   output logic       Tx_BUSY
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [2:0]  state_q,    state_d;
   logic [14:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]  bit_tick_q, bit_tick_d;
   logic [2:0]  bit_idx_q,  bit_idx_d;
   logic [7:0]  data_q,     data_d;
   logic        parity_q,   parity_d;
   logic [2:0]  baud_q,     baud_d;
   logic        txd_q,      txd_d;
   logic        busy_q,     busy_d;

   logic [14:0] div_m1;
   logic        tick;
   logic        bit_done;
   logic        accept;

   // Terminal count of the sample-tick counter for the latched rate code
   always_comb begin
      case (baud_q)
         3'd0:    div_m1 = 15'd20832;
         3'd1:    div_m1 = 15'd5207;
         3'd2:    div_m1 = 15'd1301;
         3'd3:    div_m1 = 15'd650;
         3'd4:    div_m1 = 15'd325;
         3'd5:    div_m1 = 15'd162;
         3'd6:    div_m1 = 15'd108;
         default: div_m1 = 15'd53;
      endcase
   end

   assign accept   = Tx_WR & Tx_EN & ~busy_q;
   assign tick     = (tick_cnt_q == div_m1);
   assign bit_done = tick & (bit_tick_q == 4'd15);

   // State and datapath registers; reset returns the line to idle-high
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= 15'd0;
         bit_tick_q <= 4'd0;
         bit_idx_q  <= 3'd0;
         data_q     <= 8'd0;
         parity_q   <= 1'b0;
         baud_q     <= 3'd0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_tick_q <= bit_tick_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         parity_q   <= parity_d;
         baud_q     <= baud_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic: write acceptance, tick counting and bit sequencing
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_tick_d = bit_tick_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      parity_d   = parity_q;
      baud_d     = baud_q;

      if (!Tx_EN) begin
         // Disabling aborts any frame; it is not resumed later
         state_d    = ST_IDLE;
         tick_cnt_d = 15'd0;
         bit_tick_d = 4'd0;
         bit_idx_d  = 3'd0;
      end else if (state_q == ST_IDLE) begin
         if (accept) begin
            state_d    = ST_START;
            data_d     = Tx_DATA;
            parity_d   = ^Tx_DATA;
            baud_d     = baud_select;
            tick_cnt_d = 15'd0;
            bit_tick_d = 4'd0;
            bit_idx_d  = 3'd0;
         end
      end else begin
         tick_cnt_d = tick ? 15'd0 : tick_cnt_q + 15'd1;
         if (tick) begin
            bit_tick_d = bit_tick_q + 4'd1;
         end
         if (bit_done) begin
            case (state_q)
               ST_START: begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
               end
               ST_DATA: begin
                  if (bit_idx_q == 3'd7) begin
                     state_d = ST_PARITY;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
               ST_PARITY: state_d = ST_STOP;
               default: begin
                  state_d   = ST_IDLE;
                  bit_idx_d = 3'd0;
               end
            endcase
         end
         if (state_q > ST_STOP) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Output logic: line level and busy flag for the upcoming state, registered
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != ST_IDLE);
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = data_d[bit_idx_d];
         ST_PARITY: txd_d = parity_d;
         default:   txd_d = 1'b1;
      endcase
   end

   assign TxD     = txd_q;
   assign Tx_BUSY = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transmitter
//  Purpose  : Self-checking bench for uart_transmitter. A timeline model
//             (elapsed cycles since acceptance -> frame bit) predicts TxD and
//             Tx_BUSY every cycle; directed mid-bit samples and busy-length
//             counts cover the frame contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] Tx_DATA;
   logic [2:0] baud_select;
   logic       Tx_WR;
   logic       Tx_EN;
   logic       TxD;
   logic       Tx_BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   uart_transmitter dut (
      .clk         (clk),
      .reset       (reset),
      .Tx_DATA     (Tx_DATA),
      .baud_select (baud_select),
      .Tx_WR       (Tx_WR),
      .Tx_EN       (Tx_EN),
      .TxD         (TxD),
      .Tx_BUSY     (Tx_BUSY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Clocks per sample tick: 100 MHz / (16 * baud), rounded to nearest
   function automatic int div_of(input logic [2:0] b);
      int rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
      return (100_000_000 + 8 * rates[b]) / (16 * rates[b]);
   endfunction

   // Reference model: a frame is 11 bits of 16*D clocks each, starting the
   // cycle after acceptance; reset and Tx_EN=0 drop it immediately.
   bit          m_active = 1'b0;
   int          m_k      = 0;
   int          m_d      = 54;
   logic [10:0] m_frame  = 11'h7FF;
   logic        m_txd    = 1'b1;
   logic        m_busy   = 1'b0;
   bit          chk_on   = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
      end else if (!Tx_EN) begin
         m_active = 1'b0;
      end else if (m_active) begin
         m_k++;
         if (m_k == 176 * m_d) m_active = 1'b0;
      end else if (Tx_WR) begin
         m_active = 1'b1;
         m_k      = 0;
         m_d      = div_of(baud_select);
         m_frame  = {1'b1, ^Tx_DATA, Tx_DATA, 1'b0};
      end
      m_txd  = m_active ? m_frame[m_k / (16 * m_d)] : 1'b1;
      m_busy = m_active;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("txd_model", {31'd0, TxD}, {31'd0, m_txd});
         check("busy_model", {31'd0, Tx_BUSY}, {31'd0, m_busy});
      end
   end

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Issue a one-cycle write; returns at frame offset 1 (first start-bit cycle)
   task automatic send(input logic [7:0] d, input logic [2:0] b);
      Tx_DATA     = d;
      baud_select = b;
      Tx_EN       = 1'b1;
      Tx_WR       = 1'b1;
      cycle();
      Tx_WR       = 1'b0;
      Tx_DATA     = 8'($urandom);
   endtask

   // Walk frame offsets first..last, sampling TxD at each bit centre
   task automatic watch(input string tag, input int d, input logic [10:0] bits,
                        input int first, input int last, inout int busy_n);
      for (int c = first; c <= last; c++) begin
         int k;
         k = c - 1;
         if ((k % (16 * d)) == 8 * d && (k / (16 * d)) < 11)
            check(tag, {31'd0, TxD}, {31'd0, bits[k / (16 * d)]});
         if (Tx_BUSY) busy_n++;
         cycle();
      end
   endtask

   initial begin
      int          bn;
      logic [7:0]  rd;
      reset       = 1'b1;
      Tx_DATA     = 8'h00;
      baud_select = 3'd0;
      Tx_WR       = 1'b0;
      Tx_EN       = 1'b1;
      idle(3);
      reset = 1'b0;
      cycle();
      check("reset_txd", {31'd0, TxD}, 32'd1);
      check("reset_busy", {31'd0, Tx_BUSY}, 32'd0);
      chk_on = 1'b1;

      // 0xAA at 115200, ignored write of 0x33 mid-frame, then back-to-back 0x01
      send(8'hAA, 3'd7);
      bn = 0;
      watch("aa_bit", 54, 11'b1_0_10101010_0, 1, 4000, bn);
      Tx_DATA = 8'h33;
      Tx_WR   = 1'b1;
      watch("aa_bit", 54, 11'b1_0_10101010_0, 4001, 4001, bn);
      Tx_WR   = 1'b0;
      baud_select = 3'($urandom);
      watch("aa_bit", 54, 11'b1_0_10101010_0, 4002, 9504, bn);
      check("aa_busy_len", bn, 32'd9504);
      check("aa_busy_fall", {31'd0, Tx_BUSY}, 32'd0);
      send(8'h01, 3'd7);
      check("b2b_start", {31'd0, TxD}, 32'd0);
      bn = 0;
      watch("x01_bit", 54, 11'b1_1_00000001_0, 1, 9504, bn);
      check("x01_busy_len", bn, 32'd9504);

      // 0xFF: parity 0
      idle($urandom_range(1, 20));
      send(8'hFF, 3'd7);
      bn = 0;
      watch("xff_bit", 54, 11'b1_0_11111111_0, 1, 9504, bn);
      check("xff_busy_len", bn, 32'd9504);

      // 0x5C at 9600 with a rate change mid-frame, then disable during DATA
      idle($urandom_range(1, 20));
      send(8'h5C, 3'd3);
      bn = 0;
      watch("x5c_bit", 651, 11'b1_0_01011100_0, 1, 5000, bn);
      baud_select = 3'd7;
      watch("x5c_bit", 651, 11'b1_0_01011100_0, 5001, 23000, bn);
      check("x5c_busy_len", bn, 32'd23000);
      Tx_EN = 1'b0;
      cycle();
      check("abort_txd", {31'd0, TxD}, 32'd1);
      check("abort_busy", {31'd0, Tx_BUSY}, 32'd0);
      Tx_DATA = 8'h00;
      Tx_WR   = 1'b1;
      cycle();
      Tx_WR   = 1'b0;
      cycle();
      check("dis_wr_txd", {31'd0, TxD}, 32'd1);
      check("dis_wr_busy", {31'd0, Tx_BUSY}, 32'd0);
      Tx_EN = 1'b1;

      // 0x00 interrupted by reset during the parity bit
      idle($urandom_range(1, 20));
      send(8'h00, 3'd7);
      bn = 0;
      watch("x00_bit", 54, 11'b1_0_00000000_0, 1, 8000, bn);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_mid_txd", {31'd0, TxD}, 32'd1);
      check("rst_mid_busy", {31'd0, Tx_BUSY}, 32'd0);

      // Enable and write rise together, 0xC3 full frame
      Tx_EN = 1'b0;
      idle(3);
      send(8'hC3, 3'd7);
      bn = 0;
      watch("xc3_bit", 54, 11'b1_0_11000011_0, 1, 9504, bn);
      check("xc3_busy_len", bn, 32'd9504);

      // Random payloads with random rate-code churn during the frame
      for (int f = 0; f < 2; f++) begin
         idle($urandom_range(1, 20));
         rd = 8'($urandom);
         send(rd, 3'd7);
         bn = 0;
         watch("rnd_bit", 54, {1'b1, ^rd, rd, 1'b0}, 1, 3000, bn);
         baud_select = 3'($urandom);
         watch("rnd_bit", 54, {1'b1, ^rd, rd, 1'b0}, 3001, 9504, bn);
         check("rnd_busy_len", bn, 32'd9504);
      end

      idle(5);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameters: none; divisor table fixed for 100 MHz clk.
REQ-002 clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Tx_DATA  input  8  byte to send; sampled only on an accepted write.
REQ-005 baud_select  input  3  rate code; 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-006 Tx_WR  input  1  one-cycle write strobe requesting transmission of Tx_DATA.
REQ-007 Tx_EN  input  1  transmitter enable; 0 forces idle.
REQ-008 TxD  output  1  serial line, idle-high.
REQ-009 Tx_BUSY  output  1  high from write acceptance until end of stop bit.

Function
REQ-010 Sample tick: internal counter SHALL pulse once every D clocks, D = 20833, 5208, 1302, 651, 326, 163, 109, 54 for baud_select 0..7.
REQ-011 Bit period SHALL be exactly 16 sample ticks (16*D clocks).
REQ-012 Frame SHALL be: start (0), Tx_DATA[0]..Tx_DATA[7] LSB first, parity, stop (1); 11 bits, 176*D clocks.
REQ-013 Parity bit SHALL be XOR of the 8 latched data bits (even parity: total ones in data+parity even).
REQ-014 Write accepted iff Tx_WR=1 and Tx_EN=1 and Tx_BUSY=0 in the same cycle.
REQ-015 Tx_WR with Tx_BUSY=1 or Tx_EN=0 SHALL be ignored, no queuing.
REQ-016 On acceptance at cycle N: Tx_DATA and baud_select latched; tick counter and bit-tick counter cleared; Tx_BUSY=1 and TxD=0 (start bit) from cycle N+1.
REQ-017 baud_select changes during a frame SHALL have no effect until the next accepted write.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: TxD=1, Tx_BUSY=0; -> START on accepted write.
REQ-020 START -> DATA after 16 ticks; DATA -> PARITY after 8 bits of 16 ticks each (3-bit index 0..7, no wrap past 7); PARITY -> STOP after 16 ticks; STOP -> IDLE after 16 ticks.
REQ-021 TxD SHALL be registered and change only on bit boundaries; no glitches within a bit.
REQ-022 Tx_BUSY SHALL fall in the cycle after the last stop-bit tick; a Tx_WR in the first cycle with Tx_BUSY=0 SHALL be accepted (back-to-back frames, no extra idle bit required).
REQ-023 Tx_EN falling mid-frame: next cycle FSM -> IDLE, TxD=1, Tx_BUSY=0; frame aborted, not resumed.
REQ-024 Tx_WR and Tx_EN rising in same cycle SHALL be accepted.

Reset
REQ-025 reset=1 at a rising edge: next cycle state=IDLE, TxD=1, Tx_BUSY=0, all counters and latched data/parity/baud = 0.
REQ-026 reset SHALL override every other input, including mid-frame; frame aborted.
REQ-027 After reset release, first accepted write SHALL produce a complete, correctly timed frame.

Verification
REQ-028 reset, Tx_EN=1, baud_select=7, Tx_WR pulse with Tx_DATA=0xAA -> TxD = 0,0,1,0,1,0,1,0,1,0,1, each bit 864 clocks; Tx_BUSY high 9504 clocks.
REQ-029 baud_select=7, Tx_DATA=0x01 -> parity bit 1; Tx_DATA=0x00 -> parity 0; Tx_DATA=0xFF -> parity 0.
REQ-030 baud_select=3, Tx_DATA=0x5C -> each bit 10416 clocks; baud_select changed to 7 mid-frame -> timing unchanged.
REQ-031 Tx_WR with Tx_DATA=0x33 during busy -> ignored, line carries only first byte; Tx_WR in first non-busy cycle -> second frame starts next cycle, stop bit exactly 864 clocks.
REQ-032 Tx_EN=0 during DATA -> next cycle TxD=1, Tx_BUSY=0; Tx_WR while Tx_EN=0 -> TxD stays 1.
REQ-033 reset asserted in PARITY state -> next cycle TxD=1, Tx_BUSY=0; subsequent 0xC3 write transmits correct full frame.
